// File: rtl/mii_pkg.sv
// Shared types and constants for the MII/RMII receive framer.
// Holds the FSM state encoding, the per-frame status word and address helpers.
package mii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } state_e;

    // Packed so that addr_miss lands on bit 4 and err_phy on bit 0.
    typedef struct packed {
        logic addr_miss;
        logic runt;
        logic err_long;
        logic err_dribble;
        logic err_phy;
    } rx_status_t;

    localparam logic [7:0]  C_SFD     = 8'hD5;
    localparam logic [47:0] C_BRDCST  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [15:0] C_MIN_LEN = 16'd64;

    // Byte idx (0..5) of a station address, byte 47:40 being the first on the wire.
    function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] idx);
        logic [47:0] sh;
        sh = addr >> (6'd40 - {idx, 3'b000});
        return sh[7:0];
    endfunction

endpackage

// File: rtl/mii_rx_framer_if.sv
// PHY-side inputs and byte-stream outputs of the receive framer.
// Handshake: rx_byte is meaningful only in the cycle rx_byte_vld=1; rx_status/rx_len with rx_eof.
interface mii_rx_framer_if #(
    parameter int P_DATA_W = 4
);
    import mii_pkg::*;

    logic [P_DATA_W-1:0] rx_data;
    logic                rx_dv;
    logic                rx_er;
    logic                col;
    logic [7:0]          rx_byte;
    logic                rx_byte_vld;
    logic                rx_sof;
    logic                rx_eof;
    logic [4:0]          rx_status;
    logic [15:0]         rx_len;
    state_e              dbg_state;

    modport master (
        output rx_data, rx_dv, rx_er, col,
        input  rx_byte, rx_byte_vld, rx_sof, rx_eof, rx_status, rx_len, dbg_state
    );

    modport slave (
        input  rx_data, rx_dv, rx_er, col,
        output rx_byte, rx_byte_vld, rx_sof, rx_eof, rx_status, rx_len, dbg_state
    );

endinterface

// File: rtl/mii_beat2byte.sv
// Beat-to-byte assembler: PHY beats shift in at the MSB end so bytes form LSB first.
// byte_done_o flags the beat that completes a byte; sr_next_o is that byte.
module mii_beat2byte #(
    parameter int P_DATA_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic                clr_i,
    input  logic [P_DATA_W-1:0] beat_i,
    output logic [7:0]          sr_next_o,
    output logic [1:0]          beat_cnt_o,
    output logic                byte_done_o
);

    localparam logic [1:0] C_LAST = 2'(8 / P_DATA_W - 1);

    logic [7:0] sr_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    assign sr_next_o   = 8'({beat_i, sr_q} >> P_DATA_W);
    assign byte_done_o = shift_i && (cnt_q == C_LAST);
    assign beat_cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || clr_i) begin
            cnt_d = 2'd0;
        end else if (shift_i) begin
            cnt_d = byte_done_o ? 2'd0 : cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= 8'd0;
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (load_i) begin
                sr_q <= {beat_i, {(8 - P_DATA_W){1'b0}}};
            end else if (shift_i) begin
                sr_q <= sr_next_o;
            end
        end
    end

endmodule

// File: rtl/mii_rx_framer.sv
// MII/RMII receive framer: finds the SFD, emits post-SFD bytes with sof/eof strobes,
// filters on destination address and reports length and error status per frame.
module mii_rx_framer
    import mii_pkg::*;
#(
    parameter int          P_DATA_W    = 4,
    parameter logic [47:0] P_MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter bit          P_ADDR_FILT = 1'b1,
    parameter int          P_MAX_LEN   = 1518
) (
    input  logic             rx_clk,
    input  logic             rx_rst,
    mii_rx_framer_if.slave   rx_if
);

    state_e     state_q;
    logic [15:0] byte_cnt_q;
    logic        err_phy_q;
    logic        err_long_q;
    logic        mac_ok_q;
    logic        bc_ok_q;
    logic        addr_miss_q;
    logic [7:0]  rx_byte_q;
    logic        rx_byte_vld_q;
    logic        rx_sof_q;
    logic        rx_eof_q;
    rx_status_t  status_q;
    logic [15:0] len_q;

    logic        b2b_load;
    logic        b2b_shift;
    logic        b2b_clr;
    logic [7:0]  sr_next;
    logic [1:0]  beat_cnt;
    logic        byte_done;
    logic        sfd_hit;
    logic        mac_hit;
    logic        bc_hit;
    logic [15:0] cnt_inc;
    rx_status_t  status_d;

    assign sfd_hit   = (sr_next == C_SFD);
    assign b2b_load  = (state_q == ST_IDLE) && rx_if.rx_dv;
    assign b2b_shift = rx_if.rx_dv && ((state_q == ST_PREAMBLE) || (state_q == ST_DATA));
    assign b2b_clr   = (state_q == ST_PREAMBLE) && rx_if.rx_dv && sfd_hit;

    mii_beat2byte #(
        .P_DATA_W(P_DATA_W)
    ) u_beat2byte (
        .clk        (rx_clk),
        .rst        (rx_rst),
        .load_i     (b2b_load),
        .shift_i    (b2b_shift),
        .clr_i      (b2b_clr),
        .beat_i     (rx_if.rx_data),
        .sr_next_o  (sr_next),
        .beat_cnt_o (beat_cnt),
        .byte_done_o(byte_done)
    );

    assign mac_hit = (sr_next == addr_byte(P_MAC_ADDR, byte_cnt_q[2:0]));
    assign bc_hit  = (sr_next == addr_byte(C_BRDCST, byte_cnt_q[2:0]));
    assign cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

    // Frames too short to carry a full destination address count as a miss.
    always_comb begin
        status_d             = '0;
        status_d.addr_miss   = P_ADDR_FILT && ((byte_cnt_q < 16'd6) || addr_miss_q);
        status_d.runt        = (byte_cnt_q < C_MIN_LEN);
        status_d.err_long    = err_long_q;
        status_d.err_dribble = (beat_cnt != 2'd0);
        status_d.err_phy     = err_phy_q ||
                               ((state_q == ST_DATA) && (rx_if.rx_er || rx_if.col));
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= 16'd0;
            err_phy_q     <= 1'b0;
            err_long_q    <= 1'b0;
            mac_ok_q      <= 1'b0;
            bc_ok_q       <= 1'b0;
            addr_miss_q   <= 1'b0;
            rx_byte_q     <= 8'd0;
            rx_byte_vld_q <= 1'b0;
            rx_sof_q      <= 1'b0;
            rx_eof_q      <= 1'b0;
            status_q      <= '0;
            len_q         <= 16'd0;
        end else begin
            rx_byte_vld_q <= 1'b0;
            rx_sof_q      <= 1'b0;
            rx_eof_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_if.rx_dv) begin
                        state_q <= ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (!rx_if.rx_dv) begin
                        state_q <= ST_IDLE;
                    end else if (sfd_hit) begin
                        state_q     <= ST_DATA;
                        byte_cnt_q  <= 16'd0;
                        err_phy_q   <= 1'b0;
                        err_long_q  <= 1'b0;
                        mac_ok_q    <= 1'b1;
                        bc_ok_q     <= 1'b1;
                        addr_miss_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (rx_if.rx_er || rx_if.col) begin
                        err_phy_q <= 1'b1;
                    end
                    if (!rx_if.rx_dv) begin
                        state_q  <= ST_IDLE;
                        rx_eof_q <= 1'b1;
                        status_q <= status_d;
                        len_q    <= byte_cnt_q;
                    end else if (byte_done) begin
                        byte_cnt_q <= cnt_inc;
                        if (byte_cnt_q == 16'(P_MAX_LEN)) begin
                            state_q    <= ST_DROP;
                            err_long_q <= 1'b1;
                        end else begin
                            rx_byte_q     <= sr_next;
                            rx_byte_vld_q <= 1'b1;
                            rx_sof_q      <= (byte_cnt_q == 16'd0);
                            if (byte_cnt_q < 16'd6) begin
                                mac_ok_q <= mac_ok_q && mac_hit;
                                bc_ok_q  <= bc_ok_q && bc_hit;
                                if (byte_cnt_q == 16'd5) begin
                                    addr_miss_q <= !((mac_ok_q && mac_hit) || (bc_ok_q && bc_hit));
                                end
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (!rx_if.rx_dv) begin
                        state_q  <= ST_IDLE;
                        rx_eof_q <= 1'b1;
                        status_q <= status_d;
                        len_q    <= byte_cnt_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_if.rx_byte     = rx_byte_q;
    assign rx_if.rx_byte_vld = rx_byte_vld_q;
    assign rx_if.rx_sof      = rx_sof_q;
    assign rx_if.rx_eof      = rx_eof_q;
    assign rx_if.rx_status   = status_q;
    assign rx_if.rx_len      = len_q;
    assign rx_if.dbg_state   = state_q;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: a nibble-wide and a dibit-wide instance,
// byte scoreboards fed by the drivers, and per-frame eof status/length checks.
module tb_mii_rx_framer;
    import mii_pkg::*;

    localparam logic [47:0] C_MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] C_OTHER = 48'h02_00_00_00_00_02;
    localparam int          C_MAX   = 1518;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    mii_rx_framer_if #(.P_DATA_W(4)) if4();
    mii_rx_framer_if #(.P_DATA_W(2)) if2();

    mii_rx_framer #(.P_DATA_W(4), .P_MAC_ADDR(C_MAC), .P_ADDR_FILT(1'b1), .P_MAX_LEN(C_MAX))
        u_dut4 (.rx_clk(clk), .rx_rst(rst), .rx_if(if4.slave));
    mii_rx_framer #(.P_DATA_W(2), .P_MAC_ADDR(C_MAC), .P_ADDR_FILT(1'b1), .P_MAX_LEN(C_MAX))
        u_dut2 (.rx_clk(clk), .rx_rst(rst), .rx_if(if2.slave));

    logic [7:0]  exp_q4[$];
    logic [7:0]  exp_q2[$];
    logic [4:0]  st_q4[$];
    logic [4:0]  st_q2[$];
    logic [15:0] len_q4[$];
    logic [15:0] len_q2[$];
    int          nb_q4[$];
    int          nb_q2[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- monitors ----------------
    initial begin : mon4
        int idx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                idx = 0;
            end else begin
                if (if4.rx_byte_vld) begin
                    check("byte4_expected", 32'(exp_q4.size() != 0), 32'd1);
                    if (exp_q4.size() != 0) check("byte4", 32'(if4.rx_byte), 32'(exp_q4.pop_front()));
                    check("sof4", 32'(if4.rx_sof), 32'(idx == 0));
                    idx++;
                end
                if (if4.rx_eof) begin
                    st_q4.push_back(if4.rx_status);
                    len_q4.push_back(if4.rx_len);
                    nb_q4.push_back(idx);
                    idx = 0;
                end
            end
        end
    end

    initial begin : mon2
        int idx = 0;
        int cyc = 0;
        int last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                idx = 0;
            end else begin
                if (if2.rx_byte_vld) begin
                    check("byte2_expected", 32'(exp_q2.size() != 0), 32'd1);
                    if (exp_q2.size() != 0) check("byte2", 32'(if2.rx_byte), 32'(exp_q2.pop_front()));
                    check("sof2", 32'(if2.rx_sof), 32'(idx == 0));
                    if (idx > 0) check("gap2", 32'(cyc - last), 32'd4);
                    last = cyc;
                    idx++;
                end
                if (if2.rx_eof) begin
                    st_q2.push_back(if2.rx_status);
                    len_q2.push_back(if2.rx_len);
                    nb_q2.push_back(idx);
                    idx = 0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    function automatic logic [7:0] frame_byte(input logic [47:0] dst, input int i);
        logic [47:0] t;
        logic [47:0] src;
        src = 48'h02_00_00_00_00_AA;
        if (i < 6) t = dst >> (8 * (5 - i));
        else if (i < 12) t = src >> (8 * (11 - i));
        else t = 48'(i * 13 + 7);
        return t[7:0];
    endfunction

    task automatic beat4(input logic [3:0] d, input logic dv, input logic er);
        @(negedge clk);
        if4.rx_data = d;
        if4.rx_dv   = dv;
        if4.rx_er   = er;
    endtask

    task automatic beat2(input logic [1:0] d, input logic dv);
        @(negedge clk);
        if2.rx_data = d;
        if2.rx_dv   = dv;
    endtask

    task automatic byte4(input logic [7:0] b, input logic er);
        beat4(b[3:0], 1'b1, er);
        beat4(b[7:4], 1'b1, 1'b0);
    endtask

    task automatic byte2(input logic [7:0] b);
        logic [7:0] t;
        for (int k = 0; k < 4; k++) begin
            t = b >> (2 * k);
            beat2(t[1:0], 1'b1);
        end
    endtask

    // cut >= 0 stops after that many bytes with rx_dv still high.
    task automatic send4(input logic [47:0] dst, input int len, input int er_at,
                         input bit odd, input int cut);
        logic [7:0] b;
        for (int p = 0; p < 7; p++) byte4(8'h55, 1'b0);
        byte4(C_SFD, 1'b0);
        for (int i = 0; i < len; i++) begin
            if (cut >= 0 && i == cut) return;
            b = frame_byte(dst, i);
            if (i < C_MAX) exp_q4.push_back(b);
            byte4(b, i == er_at);
        end
        if (odd) beat4(4'hA, 1'b1, 1'b0);
        beat4(4'h0, 1'b0, 1'b0);
    endtask

    task automatic send2(input logic [47:0] dst, input int len);
        logic [7:0] b;
        for (int p = 0; p < 7; p++) byte2(8'h55);
        byte2(C_SFD);
        for (int i = 0; i < len; i++) begin
            b = frame_byte(dst, i);
            exp_q2.push_back(b);
            byte2(b);
        end
        beat2(2'b00, 1'b0);
    endtask

    task automatic expect_eof4(input string tag, input logic [4:0] st, input logic [15:0] len, input int nb);
        int t = 0;
        while (st_q4.size() == 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check({tag, "_eof"}, 32'(st_q4.size() != 0), 32'd1);
        if (st_q4.size() != 0) begin
            check({tag, "_status"}, 32'(st_q4.pop_front()), 32'(st));
            check({tag, "_len"}, 32'(len_q4.pop_front()), 32'(len));
            check({tag, "_nbytes"}, 32'(nb_q4.pop_front()), 32'(nb));
        end
    endtask

    task automatic expect_eof2(input string tag, input logic [4:0] st, input logic [15:0] len, input int nb);
        int t = 0;
        while (st_q2.size() == 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check({tag, "_eof"}, 32'(st_q2.size() != 0), 32'd1);
        if (st_q2.size() != 0) begin
            check({tag, "_status"}, 32'(st_q2.pop_front()), 32'(st));
            check({tag, "_len"}, 32'(len_q2.pop_front()), 32'(len));
            check({tag, "_nbytes"}, 32'(nb_q2.pop_front()), 32'(nb));
        end
    endtask

    // ---------------- sequence ----------------
    initial begin : stim
        if4.rx_data = '0; if4.rx_dv = 1'b0; if4.rx_er = 1'b0; if4.col = 1'b0;
        if2.rx_data = '0; if2.rx_dv = 1'b0; if2.rx_er = 1'b0; if2.col = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_byte", 32'(if4.rx_byte), 32'd0);
        check("rst_vld", 32'(if4.rx_byte_vld), 32'd0);
        check("rst_sof", 32'(if4.rx_sof), 32'd0);
        check("rst_eof", 32'(if4.rx_eof), 32'd0);
        check("rst_status", 32'(if4.rx_status), 32'd0);
        check("rst_len", 32'(if4.rx_len), 32'd0);
        check("rst_state", 32'(if4.dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send4(C_MAC, 64, -1, 1'b0, -1);
        expect_eof4("f64", 5'b00000, 16'd64, 64);

        send2(C_MAC, 64);
        expect_eof2("f64_w2", 5'b00000, 16'd64, 64);

        // Second frame starts in the eof cycle of the first.
        send4(C_BRDCST, 60, -1, 1'b0, -1);
        send4(C_OTHER, 70, -1, 1'b0, -1);
        expect_eof4("bc60", 5'b01000, 16'd60, 60);
        expect_eof4("miss70", 5'b10000, 16'd70, 70);

        send4(C_MAC, 4, -1, 1'b0, -1);
        expect_eof4("short4", 5'b11000, 16'd4, 4);

        send4(C_MAC, 100, 20, 1'b0, -1);
        expect_eof4("er100", 5'b00001, 16'd100, 100);

        send4(C_MAC, 1600, -1, 1'b0, -1);
        expect_eof4("long1600", 5'b00100, 16'd1519, 1518);

        send4(C_MAC, 64, -1, 1'b1, -1);
        expect_eof4("dribble", 5'b00010, 16'd64, 64);

        send4(C_MAC, 64, -1, 1'b0, 30);
        @(negedge clk);
        #1;
        rst = 1'b1;
        if4.rx_dv = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_vld", 32'(if4.rx_byte_vld), 32'd0);
        check("midrst_len", 32'(if4.rx_len), 32'd0);
        check("midrst_status", 32'(if4.rx_status), 32'd0);
        check("midrst_state", 32'(if4.dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_eof", 32'(st_q4.size()), 32'd0);
        check("midrst_drained", 32'(exp_q4.size()), 32'd0);

        send4(C_MAC, 64, -1, 1'b0, -1);
        expect_eof4("after_rst", 5'b00000, 16'd64, 64);

        repeat (5) @(negedge clk);
        check("final_exp4_empty", 32'(exp_q4.size()), 32'd0);
        check("final_exp2_empty", 32'(exp_q2.size()), 32'd0);
        check("final_no_extra_eof", 32'(st_q4.size() + st_q2.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
